// File: rtl/led_blink_seq_if.sv
// Command channel for led_blink_seq: valid/ready handshake plus blink fields.
// Ports: cmd_valid, cmd_on, cmd_off, cmd_repeat (master->slave), cmd_ready (slave->master).
interface led_blink_seq_if #(
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_on;
    logic [CNT_W-1:0] cmd_off;
    logic [CNT_W-1:0] cmd_repeat;

    modport master (
        output cmd_valid, cmd_on, cmd_off, cmd_repeat,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_on, cmd_off, cmd_repeat,
        output cmd_ready
    );
endinterface

// File: rtl/led_blink_seq.sv
// LED blink sequencer: on/off durations in prescaled ticks, repeated N times.
// Ports: clk, rst_n, cmd (slave handshake), abort, led, busy, done.
module led_blink_seq #(
    parameter int unsigned TICK_COUNT = 50000,
    parameter int          CNT_W      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    led_blink_seq_if.slave cmd,
    input  logic          abort,
    output logic          led,
    output logic          busy,
    output logic          done
);

    localparam logic [31:0] TMAX = 32'(TICK_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      presc_q, presc_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [CNT_W-1:0] on_q, on_d;
    logic [CNT_W-1:0] off_q, off_d;

    logic tick;
    logic ph_end;

    assign tick   = (presc_q == TMAX);
    assign ph_end = tick && (dur_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            dur_q   <= '0;
            rep_q   <= '0;
            on_q    <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            dur_q   <= dur_d;
            rep_q   <= rep_d;
            on_q    <= on_d;
            off_q   <= off_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = '0;
        dur_d   = dur_q;
        rep_d   = rep_q;
        on_d    = on_q;
        off_d   = off_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    on_d  = cmd.cmd_on;
                    off_d = cmd.cmd_off;
                    if (cmd.cmd_on == '0 || cmd.cmd_repeat == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ON;
                        dur_d   = cmd.cmd_on;
                        rep_d   = cmd.cmd_repeat;
                    end
                end
            end
            S_ON, S_OFF: begin
                if (abort) begin
                    // abort beats a coincident final tick
                    state_d = S_IDLE;
                end else begin
                    // prescaler free-runs across ON/OFF boundaries
                    presc_d = tick ? '0 : presc_q + 32'd1;
                    if (tick) begin
                        dur_d = dur_q - CNT_W'(1);
                    end
                    if (ph_end) begin
                        if (state_q == S_ON && off_q != '0) begin
                            state_d = S_OFF;
                            dur_d   = off_q;
                        end else if (rep_q == CNT_W'(1)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ON;
                            rep_d   = rep_q - CNT_W'(1);
                            dur_d   = on_q;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign led           = (state_q == S_ON);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_led_blink_seq.sv
// Self-checking bench for led_blink_seq with a cycle-level timing model.
// Ports: none (top-level testbench).
module tb_led_blink_seq;

    localparam int T = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    logic led, busy, done;

    int total = 0;
    int bad   = 0;

    led_blink_seq_if #(.CNT_W(W)) cmd_if ();

    led_blink_seq #(
        .TICK_COUNT(T),
        .CNT_W(W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd(cmd_if),
        .abort(abort),
        .led(led),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Sequence length in cycles while blinking (0 for a degenerate command).
    function automatic int seq_len(input int on, input int off, input int rep);
        if (on == 0 || rep == 0) return 0;
        return rep * (on + off) * T;
    endfunction

    // Expected {led,busy,done,ready} k cycles after accept.
    function automatic logic [3:0] model(input int k, input int on,
                                         input int off, input int rep,
                                         input int ab);
        int len;
        int pos;
        len = seq_len(on, off, rep);
        if (ab > 0 && k > ab) return 4'b0001;
        if (k <= len) begin
            pos = (k - 1) % ((on + off) * T);
            return {(pos < on * T), 1'b1, 1'b0, 1'b0};
        end
        if (k == len + 1) return 4'b0110;
        return 4'b0001;
    endfunction

    task automatic rand_fields();
        cmd_if.cmd_on     = W'($urandom);
        cmd_if.cmd_off    = W'($urandom);
        cmd_if.cmd_repeat = W'($urandom);
    endtask

    // Called at a negedge while idle; ends at the negedge of the first idle cycle.
    task automatic run_cmd(input string tag, input int on, input int off,
                           input int rep, input int ab, input bit ab0,
                           input bit hold, output int ledcnt);
        int n;
        logic [3:0] e;
        logic [3:0] a;
        string nm[4];
        nm[0] = "ready"; nm[1] = "done"; nm[2] = "busy"; nm[3] = "led";
        ledcnt = 0;
        total++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s accept_ready got=%b exp=1", tag, cmd_if.cmd_ready);
        end
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_on     = W'(on);
        cmd_if.cmd_off    = W'(off);
        cmd_if.cmd_repeat = W'(rep);
        abort = ab0;
        n = (ab > 0) ? ab + 1 : seq_len(on, off, rep) + 2;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = model(k, on, off, rep, ab);
            a = {led, busy, done, cmd_if.cmd_ready};
            if (led === 1'b1) ledcnt++;
            for (int j = 0; j < 4; j++) begin
                total++;
                if (a[j] !== e[j]) begin
                    bad++;
                    $display("FAIL %s %s cyc=%0d got=%b exp=%b",
                             tag, nm[j], k, a[j], e[j]);
                end
            end
            abort = (ab == k);
            rand_fields();
            cmd_if.cmd_valid = hold && !e[0];
        end
        abort = 1'b0;
    endtask

    task automatic test_reset();
        cmd_if.cmd_valid = 1'b1;
        rand_fields();
        repeat (3) @(negedge clk);
        total += 4;
        if (led !== 1'b0) begin bad++; $display("FAIL rst_led got=%b exp=0", led); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        if (cmd_if.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_ready got=%b exp=1", cmd_if.cmd_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int c;
        run_cmd("basic", 2, 1, 2, 0, 1'b0, 1'b0, c);
        total++;
        if (c != 16) begin bad++; $display("FAIL basic_ledcnt got=%0d exp=16", c); end
    endtask

    task automatic test_off_zero();
        int c;
        run_cmd("off0", 1, 0, 3, 0, 1'b0, 1'b0, c);
        total++;
        if (c != 12) begin bad++; $display("FAIL off0_ledcnt got=%0d exp=12", c); end
    endtask

    task automatic test_degenerate();
        int c;
        run_cmd("rep0", 2, 1, 0, 0, 1'b0, 1'b0, c);
        run_cmd("on0", 0, 3, 2, 0, 1'b0, 1'b0, c);
    endtask

    task automatic test_abort();
        int c;
        run_cmd("abort5", 2, 1, 2, 5, 1'b0, 1'b0, c);
        run_cmd("abort_final", 2, 1, 2, 24, 1'b0, 1'b0, c);
        run_cmd("abort_accept", 2, 1, 2, 0, 1'b1, 1'b0, c);
    endtask

    task automatic test_hold();
        int c;
        run_cmd("hold", 2, 1, 2, 0, 1'b0, 1'b1, c);
    endtask

    task automatic test_back_to_back();
        int c;
        run_cmd("b2b_a", 1, 1, 1, 0, 1'b0, 1'b0, c);
        run_cmd("b2b_b", 3, 2, 2, 0, 1'b0, 1'b0, c);
    endtask

    task automatic test_random();
        int on, off, rep, ab, len, c;
        bit ab0, hold;
        for (int i = 0; i < 25; i++) begin
            on   = $urandom_range(0, 3);
            off  = $urandom_range(0, 3);
            rep  = $urandom_range(0, 3);
            len  = seq_len(on, off, rep);
            ab   = (len > 0 && $urandom_range(0, 3) == 0) ?
                   $urandom_range(1, len) : 0;
            ab0  = 1'($urandom_range(0, 1));
            hold = 1'($urandom_range(0, 1));
            run_cmd("rand", on, off, rep, ab, ab0, hold, c);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_on     = 8'd3;
        cmd_if.cmd_off    = 8'd1;
        cmd_if.cmd_repeat = 8'd2;
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total += 4;
        if (led !== 1'b0) begin bad++; $display("FAIL midrst_led got=%b exp=0", led); end
        if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", done); end
        if (cmd_if.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_ready got=%b exp=1", cmd_if.cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd("max", 255, 255, 1, 0, 1'b0, 1'b0, c);
        total++;
        if (c != 1020) begin bad++; $display("FAIL max_ledcnt got=%0d exp=1020", c); end
    endtask

    initial begin
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_on     = '0;
        cmd_if.cmd_off    = '0;
        cmd_if.cmd_repeat = '0;
        test_reset();
        test_basic();
        test_off_zero();
        test_degenerate();
        test_abort();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
